// File: rtl/sentinel_key_capture.sv
// sentinel_key_capture
//   Front-end of the Sentinel gate. Synchronises and debounces the 8-bit DIP
//   switch key. Each newly settled key is presented once over a valid/ready
//   handshake. The gate's pass/fail verdict is then consumed, and a run of
//   consecutive failures forces a timed lockout.
//
//   Optional feature macro: SENTINEL_LOCKOUT_ESCALATE_EN
//     When defined, each lockout entry raises a 2-bit escalation level
//     (saturating at 3). The lockout then lasts LOCKOUT_CYCLES << level,
//     using the level from before the increment. Any passing verdict clears
//     the level.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   ena          enable; low suspends new captures (the counter is held at 0)
//   sw_in[7:0]   raw switch key, asynchronous to clk
//   key_out[7:0] captured key; stable while key_valid is high
//   key_valid    key_out holds an unconsumed key
//   key_ready    gate accepts key_out this cycle
//   result_valid one-cycle verdict strobe
//   result_ok    verdict, 1 = match
//   lockout      high throughout the lockout period
//   fail_count   consecutive failed verdicts since the last success or lockout
module sentinel_key_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] sw_in,
  output logic [7:0] key_out,
  output logic       key_valid,
  input  logic       key_ready,
  input  logic       result_valid,
  input  logic       result_ok,
  output logic       lockout,
  output logic [3:0] fail_count
);

  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES * 8) + 1;
  localparam logic [7:0]    CNT_MAX    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    FAIL_LIMIT = 5'(MAX_FAILS);
  localparam logic [TW-1:0] LOCK_BASE  = TW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    WAIT_RESULT,
    LOCKOUT
  } state_t;

  state_t        state, state_n;
  logic [7:0]    sync1, sw_s, candidate, cnt;
  logic [7:0]    last_sent, last_sent_n, key_out_n;
  logic          key_valid_n, lockout_n;
  logic [3:0]    fail_n;
  logic [TW-1:0] timer, timer_n, lock_len;
  logic          settled;

`ifdef SENTINEL_LOCKOUT_ESCALATE_EN
  logic [1:0] level, level_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level <= '0;
    else     level <= level_n;
  end

  assign lock_len = LOCK_BASE << level;
`else
  assign lock_len = LOCK_BASE;
`endif

  // Synchroniser and debounce. The candidate keeps tracking in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sw_s      <= '0;
      candidate <= '0;
      cnt       <= '0;
    end else begin
      sync1 <= sw_in;
      sw_s  <= sync1;
      if (sw_s != candidate) begin
        candidate <= sw_s;
        cnt       <= '0;
      end else if (!ena) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign settled = (cnt == CNT_MAX) && (candidate != last_sent);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_out    <= '0;
      key_valid  <= 1'b0;
      last_sent  <= '0;
      fail_count <= '0;
      timer      <= '0;
      lockout    <= 1'b0;
    end else begin
      state      <= state_n;
      key_out    <= key_out_n;
      key_valid  <= key_valid_n;
      last_sent  <= last_sent_n;
      fail_count <= fail_n;
      timer      <= timer_n;
      lockout    <= lockout_n;
    end
  end

  always_comb begin
    state_n     = state;
    key_out_n   = key_out;
    key_valid_n = key_valid;
    last_sent_n = last_sent;
    fail_n      = fail_count;
    timer_n     = timer;
    lockout_n   = lockout;
`ifdef SENTINEL_LOCKOUT_ESCALATE_EN
    level_n     = level;
`endif
    case (state)
      IDLE: begin
        if (ena && settled) begin
          key_out_n   = candidate;
          last_sent_n = candidate;
          key_valid_n = 1'b1;
          state_n     = PRESENT;
        end
      end
      PRESENT: begin
        if (key_ready) begin
          key_valid_n = 1'b0;
          state_n     = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (result_valid) begin
          if (result_ok) begin
            fail_n  = '0;
            state_n = IDLE;
`ifdef SENTINEL_LOCKOUT_ESCALATE_EN
            level_n = '0;
`endif
          end else if ((5'(fail_count) + 5'd1) < FAIL_LIMIT) begin
            fail_n  = fail_count + 4'd1;
            state_n = IDLE;
          end else begin
            // The timer is loaded with length-1 and the exit happens on the
            // cycle it reads 0, so lockout stays high for exactly lock_len cycles.
            timer_n   = lock_len - TW'(1);
            lockout_n = 1'b1;
            state_n   = LOCKOUT;
`ifdef SENTINEL_LOCKOUT_ESCALATE_EN
            if (level != 2'd3) level_n = level + 2'd1;
`endif
          end
        end
      end
      LOCKOUT: begin
        if (timer == '0) begin
          lockout_n   = 1'b0;
          fail_n      = '0;
          // Mark the key currently on the switches as already sent, so that a
          // held wrong key is not resubmitted until the switches change.
          last_sent_n = candidate;
          state_n     = IDLE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sentinel_key_capture.sv
module tb_sentinel_key_capture;

  localparam int D  = 4;
  localparam int MF = 3;
  localparam int LC = 32;

  logic       clk = 1'b0;
  logic       rst, ena, key_ready, result_valid, result_ok;
  logic [7:0] sw_in, key_out;
  logic       key_valid, lockout;
  logic [3:0] fail_count;

  always #5 clk = ~clk;

  sentinel_key_capture #(
    .DEBOUNCE_CYCLES(D),
    .MAX_FAILS(MF),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .sw_in(sw_in),
    .key_out(key_out),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .result_valid(result_valid),
    .result_ok(result_ok),
    .lockout(lockout),
    .fail_count(fail_count)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [7:0] sw;
    logic       ok;
    int         exp_fail;
    int         exp_lock;  // 0 = no lockout expected, else its length in cycles
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted key must match the oldest expected key.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_present: key_out=0x%02h, no key expected", key_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("present_key", key_out, mon_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, input int bound, output int lat);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (key_valid) break;
      lat++;
      if (lat > bound) begin
        checks++;
        errors++;
        $display("FAIL %s: key_valid not seen within %0d cycles", name, bound);
        break;
      end
    end
  endtask

  // Drives the key, waits for presentation and completes the handshake
  // (key_ready must be 1). exp_lat < 0 skips the latency check.
  task automatic present_key(input string name, input logic [7:0] k, input int exp_lat);
    int lat;
    sw_in = k;
    exp_q.push_back(k);
    wait_valid(name, 40, lat);
    if (exp_lat >= 0) check({name, "_latency"}, lat, exp_lat);
    tick(1);
    check({name, "_valid_cleared"}, key_valid, 0);
  endtask

  task automatic verdict(input logic ok);
    result_valid = 1'b1;
    result_ok    = ok;
    tick(1);
    result_valid = 1'b0;
    result_ok    = 1'b0;
  endtask

  task automatic expect_quiet(input string name, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      tick(1);
      if (key_valid) hits++;
    end
    check(name, hits, 0);
  endtask

  // Called just after the verdict edge that entered lockout. Counts the cycles
  // lockout stays high; optionally changes sw_in at cycle late_k.
  task automatic measure_lockout(input int late_k, input logic [7:0] late_sw,
                                 output int len, output int kv_hits);
    len     = 1;
    kv_hits = 0;
    while (len < 400) begin
      @(posedge clk);
      #1;
      if (!lockout) break;
      if (key_valid) kv_hits++;
      len++;
      if (late_k != 0 && len == late_k + 1) sw_in = late_sw;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, len, hits, bad;

    vecs[0]  = '{8'h21, 1'b0, 1, 0};
    vecs[1]  = '{8'h22, 1'b1, 0, 0};
    vecs[2]  = '{8'h01, 1'b0, 1, 0};
    vecs[3]  = '{8'h02, 1'b0, 2, 0};
    vecs[4]  = '{8'h03, 1'b0, 0, LC};
    vecs[5]  = '{8'h04, 1'b0, 1, 0};
    vecs[6]  = '{8'h05, 1'b0, 2, 0};
`ifdef SENTINEL_LOCKOUT_ESCALATE_EN
    vecs[7]  = '{8'h06, 1'b0, 0, 2 * LC};
`else
    vecs[7]  = '{8'h06, 1'b0, 0, LC};
`endif
    vecs[8]  = '{8'h07, 1'b1, 0, 0};
    vecs[9]  = '{8'h08, 1'b0, 1, 0};
    vecs[10] = '{8'h09, 1'b0, 2, 0};

    rst = 1'b1; ena = 1'b1; key_ready = 1'b1;
    result_valid = 1'b0; result_ok = 1'b0; sw_in = 8'h00;
    #2;
    check("rst_key_valid", key_valid, 0);
    check("rst_key_out", key_out, 8'h00);
    check("rst_lockout", lockout, 0);
    check("rst_fail_count", fail_count, 0);
    tick(3);
    rst = 1'b0;

    // Asynchronous reset while a key is being presented
    key_ready = 1'b0;
    sw_in = 8'hB6;
    wait_valid("t1_present", 40, lat);
    check("t1_key_out", key_out, 8'hB6);
    tick(2);
    check("t1_held", key_valid, 1);
    sw_in = 8'h00;
    #2 rst = 1'b1;
    #1;
    check("t1_async_key_valid", key_valid, 0);
    check("t1_async_key_out", key_out, 8'h00);
    check("t1_async_lockout", lockout, 0);
    check("t1_async_fail_count", fail_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    key_ready = 1'b1;
    expect_quiet("t1_zero_not_sent", 20);

    // Basic capture, latency D+2, single presentation of a held key
    present_key("t2", 8'hB6, D + 2);
    verdict(1'b1);
    check("t2_fail_count", fail_count, 0);
    expect_quiet("t2_no_repeat", 20);

    // A verdict strobe outside WAIT_RESULT is ignored
    verdict(1'b0);
    check("stray_verdict_fail_count", fail_count, 0);
    check("stray_verdict_lockout", lockout, 0);

    // Bouncing switches: only the final settled value is sent
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 8'hB7 : 8'hB6;
      tick(2);
    end
    present_key("t3", 8'hB7, D + 2);
    verdict(1'b1);
    expect_quiet("t3_once", 12);

    // ena low holds the counter at 0; once enabled, D-1 more counts are needed
    ena = 1'b0;
    sw_in = 8'h5A;
    expect_quiet("ena_low", 20);
    ena = 1'b1;
    present_key("ena_high", 8'h5A, D - 1);
    verdict(1'b1);

    // Back-pressure: key held while key_ready is low; next key waits for the verdict
    key_ready = 1'b0;
    sw_in = 8'hB6;
    exp_q.push_back(8'hB6);
    wait_valid("t4_present", 40, lat);
    check("t4_latency", lat, D + 2);
    sw_in = 8'h11;
    bad = 0;
    repeat (10) begin
      tick(1);
      if (!key_valid || key_out != 8'hB6) bad++;
    end
    check("t4_key_held", bad, 0);
    key_ready = 1'b1;
    tick(1);
    check("t4_valid_cleared", key_valid, 0);
    expect_quiet("t4_wait_result", 10);
    verdict(1'b1);
    exp_q.push_back(8'h11);
    wait_valid("t4_next", 10, lat);
    check("t4_next_latency", lat, 0);
    tick(1);
    verdict(1'b1);

    // Table: failure counting, success clearing, lockout lengths
    for (int i = 0; i < 11; i++) begin
      present_key($sformatf("vec%0d", i), vecs[i].sw, D + 2);
      verdict(vecs[i].ok);
      if (vecs[i].exp_lock == 0) begin
        check($sformatf("vec%0d_fail_count", i), fail_count, vecs[i].exp_fail);
        check($sformatf("vec%0d_lockout", i), lockout, 0);
      end else begin
        check($sformatf("vec%0d_lockout_entry", i), lockout, 1);
        measure_lockout(0, 8'h00, len, hits);
        check($sformatf("vec%0d_lockout_len", i), len, vecs[i].exp_lock);
        check($sformatf("vec%0d_no_present_in_lockout", i), hits, 0);
        check($sformatf("vec%0d_fail_after", i), fail_count, 0);
        expect_quiet($sformatf("vec%0d_held_key_not_resent", i), 12);
      end
    end

    // Third lockout (after a success); a key changed late in lockout is
    // sent only after expiry
    present_key("t5c", 8'h0C, D + 2);
    verdict(1'b0);
    check("t5c_lockout_entry", lockout, 1);
    measure_lockout(LC - 2, 8'h0D, len, hits);
    check("t5c_lockout_len", len, LC);
    check("t5c_no_present_in_lockout", hits, 0);
    check("t5c_fail_after", fail_count, 0);
    // 0x0D first sampled at lockout cycle LC-1; it appears D+2 cycles later
    exp_q.push_back(8'h0D);
    wait_valid("t5c_after", 20, lat);
    check("t5c_after_latency", lat, D + 2 - 2);
    tick(1);
    verdict(1'b1);
    check("t5c_final_fail_count", fail_count, 0);

    tick(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sentinel_key_capture.md
Name: sentinel_key_capture

Overview:
- Upstream front-end of the Sentinel gate.
- Synchronises and debounces the 8-bit DIP-switch key, presents each newly settled key once over a valid/ready handshake, and consumes the gate's pass/fail verdict.
- Enforces a consecutive-failure lockout that blanks key submission for a fixed period.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required before a key is accepted (legal 2..255)
MAX_FAILS, 3, consecutive failed verdicts that trigger lockout (legal 1..15)
LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (legal 1..2^20)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-high
ena  input  1  power-state enable; low suspends new captures
sw_in  input  8  raw DIP switch key, asynchronous to clk
key_out  output  8  captured key to gate; stable while key_valid high
key_valid  output  1  key_out holds an unconsumed key
key_ready  input  1  gate accepts key_out this cycle
result_valid  input  1  gate verdict strobe, one cycle
result_ok  input  1  verdict: 1 = key matched, sampled with result_valid
lockout  output  1  high throughout LOCKOUT state
fail_count  output  4  consecutive failed verdicts since last success/lockout

Behaviour:
- Reset (async, active-high): state IDLE; key_out=0x00, key_valid=0, lockout=0, fail_count=0; last_sent=0x00; debounce counter=0; sync flops=0x00.
- Input path: 2-flop synchroniser on sw_in gives sw_s.
- Debounce: candidate register follows sw_s. Any cycle where sw_s != candidate loads candidate and clears the counter. Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
- Settled means the counter equals DEBOUNCE_CYCLES-1 and candidate != last_sent.
- States IDLE, PRESENT, WAIT_RESULT, LOCKOUT:
  - IDLE: if ena=1 and settled, load key_out=candidate, last_sent=candidate, set key_valid=1, go PRESENT. If ena=0, the counter is held at 0 and no capture occurs.
  - PRESENT: key_out and key_valid are held; sw_in changes are ignored (debounce keeps tracking). On key_valid&key_ready, clear key_valid next cycle and go WAIT_RESULT.
  - WAIT_RESULT: on result_valid:
    - result_ok=1: fail_count=0, go IDLE.
    - result_ok=0 and fail_count+1 < MAX_FAILS: fail_count++, go IDLE.
    - result_ok=0 and fail_count+1 == MAX_FAILS: go LOCKOUT, load timer, lockout=1 next cycle.
  - LOCKOUT: timer decrements every cycle regardless of ena. When the timer hits 0: lockout=0, fail_count=0, last_sent=candidate (a held wrong key is not resubmitted until the switches change), go IDLE.
- result_valid outside WAIT_RESULT is ignored. Verdicts are only sampled from the cycle after the handshake onward.
- Latency: with sw_in held, a change is first seen on sw_s 2 cycles later. key_valid rises DEBOUNCE_CYCLES+2 cycles after the sw_in edge is first sampled.
- Identical key re-presented after an unrelated change: allowed. Only an exact repeat of last_sent is suppressed.
- Timer width: ceil(log2(LOCKOUT_CYCLES*8))+1 bits, so the optional escalation cannot overflow.
- ena only gates capture. A pending PRESENT, WAIT_RESULT or LOCKOUT completes normally.

Optional Feature:
SENTINEL_LOCKOUT_ESCALATE_EN
- Defined:
  - A 2-bit escalation level (reset 0) increments, saturating at 3, on each LOCKOUT entry.
  - Lockout duration = LOCKOUT_CYCLES << level, using the level before the increment: 1x, 2x, 4x, then 8x thereafter.
  - Level clears to 0 on any result_ok=1 verdict. Level is unaffected by lockout expiry.
- Undefined: every lockout lasts exactly LOCKOUT_CYCLES; no escalation register.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, MAX_FAILS=3, LOCKOUT_CYCLES=32, key_ready tied 1 unless stated.)
1. Assert rst mid-PRESENT with key_out=0xB6 -> same cycle (async): key_valid=0, key_out=0x00, lockout=0, fail_count=0. After release, sw_in=0x00 is never presented.
2. sw_in 0x00->0xB6 at cycle 0 -> key_valid rises at cycle 6 with key_out=0xB6. Gate returns result_ok=1 -> fail_count=0. Holding 0xB6 produces no second presentation.
3. sw_in toggles 0xB6/0xB7 every 2 cycles for 20 cycles, then holds 0xB7 -> exactly one presentation, key_out=0xB7, 6 cycles after the last toggle.
4. key_ready=0 for 10 cycles while sw_in moves to 0x11 -> key_out stays 0xB6 with key_valid high. On key_ready=1 the handshake completes, and 0x11 is presented only after the verdict returns to IDLE.
5. Three wrong keys 0x01, 0x02, 0x03 each with result_ok=0 -> fail_count 1, 2, then lockout=1 for exactly 32 cycles. sw_in=0x04 during lockout is not presented until after expiry; fail_count=0 after expiry.
6. With SENTINEL_LOCKOUT_ESCALATE_EN: two successive lockouts -> durations 32 then 64 cycles. One result_ok=1 verdict, then a third lockout -> 32 cycles.
